// File: rtl/pc_predictor_pkg.sv
// pc_predictor_pkg: shared defaults, constants and PHT mode encoding for the fetch predictor.
package pc_predictor_pkg;
   localparam int DEF_IDX_BITS = 7;
   localparam int DEF_TAG_BITS = 9;
   localparam int DEF_CTR_BITS = 2;
   localparam int DEF_MODE = 0;
   localparam logic [31:0] PC_ZERO = 32'h0000_0000;
   typedef enum logic {PHT_BIMODAL = 1'b0, PHT_GSHARE = 1'b1} pht_mode_e;
endpackage

// File: rtl/pc_predictor_pht.sv
// pht_counters: table of saturating direction counters with one read port and one update port.
module pht_counters
   import pc_predictor_pkg::*;
#(
   parameter int IDX_BITS = DEF_IDX_BITS,
   parameter int CTR_BITS = DEF_CTR_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [CTR_BITS-1:0] rd_ctr,
   input  logic                upd_en,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic                upd_init,
   input  logic                upd_taken
);
   localparam int N = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] WEAK_N = WEAK_T - CTR_BITS'(1);
   logic [CTR_BITS-1:0] ctr_q [N];
   logic [CTR_BITS-1:0] ctr_d [N];
   logic [CTR_BITS-1:0] cur, nxt;
   assign rd_ctr = ctr_q[rd_idx];
   assign cur = ctr_q[upd_idx];
   always_comb begin
      nxt = upd_init ? (upd_taken ? WEAK_T : WEAK_N)
          : upd_taken ? ((&cur) ? cur : cur + CTR_BITS'(1))
          : ((cur == '0) ? cur : cur - CTR_BITS'(1));
      ctr_d = ctr_q;
      if (upd_en) ctr_d[upd_idx] = nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) ctr_q <= '{default: WEAK_N};
      else ctr_q <= ctr_d;
   end
endmodule

// File: rtl/pc_predictor.sv
// pc_predictor: fetch PC register with a direct-mapped BTB and bimodal/gshare direction counters.
module pc_predictor
   import pc_predictor_pkg::*;
#(
   parameter int IDX_BITS = DEF_IDX_BITS,
   parameter int TAG_BITS = DEF_TAG_BITS,
   parameter int CTR_BITS = DEF_CTR_BITS,
   parameter int MODE = DEF_MODE
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic        pred_taken,
   input  logic        jump_flag,
   input  logic [31:0] branch_to,
   input  logic [4:0]  stall_signal,
   input  logic        branch_flag,
   input  logic [31:0] branch_pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target
);
   localparam int N = 1 << IDX_BITS;
   localparam bit GSHARE = (MODE == int'(PHT_GSHARE));
   logic [31:0] pc_q, pc_d;
   logic pred_q, pred_d;
   logic [N-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q [N];
   logic [TAG_BITS-1:0] tag_d [N];
   logic [31:0] tgt_q [N];
   logic [31:0] tgt_d [N];
   logic [IDX_BITS-1:0] ghr_q, ghr_d, bidx, pidx, uidx, upd_pidx;
   logic [TAG_BITS-1:0] ptag, utag;
   logic [CTR_BITS-1:0] rd_ctr;
   logic hit, uhit, take, upd_en;
   logic unused_bits;
   assign bidx = pc_q[IDX_BITS+1:2];
   assign ptag = pc_q[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign uidx = branch_pc[IDX_BITS+1:2];
   assign utag = branch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
   assign hit = valid_q[bidx] && tag_q[bidx] == ptag;
   assign uhit = valid_q[uidx] && tag_q[uidx] == utag;
   assign pidx = GSHARE ? bidx ^ ghr_q : bidx;
   assign upd_pidx = GSHARE ? uidx ^ ghr_q : uidx;
   assign take = hit && rd_ctr[CTR_BITS-1];
   assign upd_en = branch_flag && !rst;
   assign pc = pc_q;
   assign pred_taken = pred_q;
   assign unused_bits = ^{stall_signal, branch_pc, pc_q};
   pht_counters #(.IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS)) u_pht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pidx),
      .rd_ctr    (rd_ctr),
      .upd_en    (upd_en),
      .upd_idx   (upd_pidx),
      .upd_init  (!GSHARE && !uhit),
      .upd_taken (branch_taken)
   );
   always_comb begin
      pc_d = jump_flag ? branch_to : stall_signal[0] ? pc_q : take ? tgt_q[bidx] : pc_q + 32'd4;
      pred_d = jump_flag ? 1'b0 : stall_signal[0] ? pred_q : take;
      valid_d = branch_flag ? (valid_q | (N'(1) << uidx)) : valid_q;
      ghr_d = branch_flag ? ((ghr_q << 1) | IDX_BITS'(branch_taken)) : ghr_q;
      tag_d = tag_q;
      tgt_d = tgt_q;
      if (upd_en) begin
         tag_d[uidx] = utag;
         if (branch_taken) tgt_d[uidx] = branch_target;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= PC_ZERO;
         pred_q <= 1'b0;
         valid_q <= '0;
         ghr_q <= '0;
      end else begin
         pc_q <= pc_d;
         pred_q <= pred_d;
         valid_q <= valid_d;
         ghr_q <= ghr_d;
      end
   end
   // tag/target storage is meaningful only under valid, so it carries no reset
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end
endmodule
